// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arbstate_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the requester that did not win last takes a tie.
// Combinational pick; last-winner register updates when update is high.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       winner,
  output logic       valid
);

  logic last_q, last_d;

  always_comb begin
    valid  = |req;
    winner = (&req) ? ~last_q : req[1];
    last_d = last_q;
    if (update && valid) last_d = winner;
  end

  // Reset to dma so that the cpu wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= REQ_DMA;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between the core and a DMA/loader port.
// Round-robin grant in IDLE, LAT wait cycles in BUSY, one-cycle ready pulse in DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          dma_req,
  input  logic          cpu_we,
  input  logic          dma_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic [DW-1:0] dma_rdata,
  output logic          cpu_ready,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant,
  output logic          busy
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  arbstate_t     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          grant_q, grant_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic [1:0] arb_req;
  logic       arb_update, arb_winner, arb_valid;

  // In DONE the arbiter sees only the finished owner so its last-winner records it.
  assign arb_req    = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : {dma_req, cpu_req};
  assign arb_update = (state_q == DONE);

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .update (arb_update),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    grant_d     = grant_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          we_d    = (arb_winner == REQ_DMA) ? dma_we    : cpu_we;
          addr_d  = (arb_winner == REQ_DMA) ? dma_addr  : cpu_addr;
          wdata_d = (arb_winner == REQ_DMA) ? dma_wdata : cpu_wdata;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_q == REQ_DMA) dma_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= REQ_CPU;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      grant_q     <= grant_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // The strobe is masked by reset so an aborted write never reaches memory.
  assign mem_en    = (state_q == BUSY);
  assign mem_we    = mem_en && we_q && (cnt_q == CNT_INIT) && !reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ready = (state_q == DONE) && (grant_q == REQ_CPU);
  assign dma_ready = (state_q == DONE) && (grant_q == REQ_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT 2, 3, 1) against a fixed-latency memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[N];
  logic        cpu_req[N], dma_req[N], cpu_we[N], dma_we[N];
  logic [31:0] cpu_addr[N], dma_addr[N], cpu_wdata[N], dma_wdata[N];
  logic [31:0] cpu_rdata[N], dma_rdata[N], mem_addr[N], mem_wdata[N], mem_rdata[N];
  logic        cpu_ready[N], dma_ready[N], mem_en[N], mem_we[N], grant[N], busy[N];

  logic [31:0] mem [256];
  logic        load_mem;
  int          en_run[N];
  int          cyc = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(.AW(32), .DW(32), .LAT(g == 0 ? 2 : (g == 1 ? 3 : 1))) u_dut (
      .clk(clk), .reset(rst[g]),
      .cpu_req(cpu_req[g]), .dma_req(dma_req[g]), .cpu_we(cpu_we[g]), .dma_we(dma_we[g]),
      .cpu_addr(cpu_addr[g]), .dma_addr(dma_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .dma_wdata(dma_wdata[g]),
      .cpu_rdata(cpu_rdata[g]), .dma_rdata(dma_rdata[g]),
      .cpu_ready(cpu_ready[g]), .dma_ready(dma_ready[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .grant(grant[g]), .busy(busy[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
  endfunction

  // Memory: data is valid only in the LAT-th consecutive mem_en cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) en_run[k] <= mem_en[k] ? en_run[k] + 1 : 0;
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    end else begin
      for (int k = 0; k < N; k++) if (mem_we[k]) mem[mem_addr[k][9:2]] <= mem_wdata[k];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++)
      mem_rdata[k] = (mem_en[k] && en_run[k] == lat_of(k) - 1) ? mem[mem_addr[k][9:2]] : 32'hBAD0BAD0;
  end

  typedef struct {
    int          inst;
    logic        who;
    logic        rd;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    int          inst;
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[10];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt[N], we_cnt[N];
  logic [31:0] we_addr[N], we_data[N];
  logic        seen_cpu[N], seen_dma[N];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(int k, logic who, logic rd, logic [31:0] d, int c);
    exp_t e;
    e.inst = k; e.who = who; e.rd = rd; e.rdata = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Advance to the next falling edge, sample every instance and retire scoreboard entries.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      seen_cpu[k] = cpu_ready[k];
      seen_dma[k] = dma_ready[k];
      if (mem_en[k]) en_cnt[k]++;
      if (mem_we[k]) begin
        we_cnt[k]++;
        we_addr[k] = mem_addr[k];
        we_data[k] = mem_wdata[k];
      end
      if (cpu_ready[k] || dma_ready[k]) begin
        chk("ready_onehot", 32'(cpu_ready[k] & dma_ready[k]), 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready inst=%0d cpu=%b dma=%b required none (cycle %0d)",
                   k, cpu_ready[k], dma_ready[k], cyc);
        end else begin
          e = sbq.pop_front();
          chk("sb_inst", 32'(k), 32'(e.inst));
          chk("sb_who", 32'(dma_ready[k]), 32'(e.who));
          chk("sb_cycle", 32'(cyc), 32'(e.cyc));
          if (e.rd) chk("sb_rdata", e.who ? dma_rdata[k] : cpu_rdata[k], e.rdata);
        end
      end
    end
  endtask

  task automatic drive(int k, logic who, logic req, logic we, logic [31:0] a, logic [31:0] d);
    if (who == REQ_DMA) begin
      dma_req[k] = req; dma_we[k] = we; dma_addr[k] = a; dma_wdata[k] = d;
    end else begin
      cpu_req[k] = req; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d;
    end
  endtask

  task automatic check_idle(int k);
    chk("idle_busy", 32'(busy[k]), 32'd0);
    chk("idle_mem_en", 32'(mem_en[k]), 32'd0);
    chk("idle_mem_we", 32'(mem_we[k]), 32'd0);
    chk("idle_mem_addr", mem_addr[k], 32'd0);
    chk("idle_mem_wdata", mem_wdata[k], 32'd0);
    chk("idle_grant", 32'(grant[k]), 32'd0);
    chk("idle_cpu_ready", 32'(cpu_ready[k]), 32'd0);
    chk("idle_dma_ready", 32'(dma_ready[k]), 32'd0);
    chk("idle_cpu_rdata", cpu_rdata[k], 32'd0);
    chk("idle_dma_rdata", dma_rdata[k], 32'd0);
  endtask

  task automatic wait_ready(int k, logic who, int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      got = (who == REQ_DMA) ? seen_dma[k] : seen_cpu[k];
    end
    chk("ready_timeout", 32'(got), 32'd1);
  endtask

  // One isolated access; called with the DUT idle so the next edge is the grant edge.
  task automatic do_single(vec_t v);
    int          k      = v.inst;
    int          lat    = lat_of(v.inst);
    int          en0    = en_cnt[v.inst];
    int          we0    = we_cnt[v.inst];
    logic [31:0] other0 = (v.who == REQ_DMA) ? cpu_rdata[v.inst] : dma_rdata[v.inst];
    logic [31:0] own0   = (v.who == REQ_DMA) ? dma_rdata[v.inst] : cpu_rdata[v.inst];
    push_exp(k, v.who, !v.we, v.exp_rd, cyc + 1 + lat);
    drive(k, v.who, 1'b1, v.we, v.addr, v.wdata);
    wait_ready(k, v.who, 20);
    drive(k, v.who, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("en_cycles", 32'(en_cnt[k] - en0), 32'(lat));
    chk("we_strobes", 32'(we_cnt[k] - we0), 32'(v.we));
    if (v.we) begin
      chk("we_addr", we_addr[k], v.addr);
      chk("we_data", we_data[k], v.wdata);
      chk("wr_own_rdata_kept", (v.who == REQ_DMA) ? dma_rdata[k] : cpu_rdata[k], own0);
    end
    chk("other_rdata_kept", (v.who == REQ_DMA) ? cpu_rdata[k] : dma_rdata[k], other0);
    tick();
  endtask

  initial begin
    int c;
    int n;

    vecs[0] = '{0, REQ_CPU, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{0, REQ_DMA, 1'b0, 32'h14, 32'h0,        32'hC0DE0005};
    vecs[2] = '{0, REQ_DMA, 1'b1, 32'h40, 32'h12345678, 32'h0};
    vecs[3] = '{0, REQ_DMA, 1'b0, 32'h40, 32'h0,        32'h12345678};
    vecs[4] = '{0, REQ_CPU, 1'b1, 32'h08, 32'hA5A5A5A5, 32'h0};
    vecs[5] = '{0, REQ_CPU, 1'b0, 32'h08, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{2, REQ_CPU, 1'b0, 32'h30, 32'h0,        32'hC0DE000C};
    vecs[7] = '{2, REQ_DMA, 1'b1, 32'h34, 32'h0BADCAFE, 32'h0};
    vecs[8] = '{2, REQ_DMA, 1'b0, 32'h34, 32'h0,        32'h0BADCAFE};
    vecs[9] = '{1, REQ_DMA, 1'b0, 32'h24, 32'h0,        32'hC0DE0009};

    load_mem = 1'b1;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1;
      drive(k, REQ_CPU, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(k, REQ_DMA, 1'b0, 1'b0, 32'd0, 32'd0);
      en_cnt[k] = 0; we_cnt[k] = 0; we_addr[k] = '0; we_data[k] = '0;
      seen_cpu[k] = 1'b0; seen_dma[k] = 1'b0;
    end
    repeat (3) tick();
    for (int k = 0; k < N; k++) check_idle(k);
    load_mem = 1'b0;
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    tick();

    // Both requesters held, each acknowledging its ready: cpu, dma, cpu, dma every LAT+2.
    c = cyc;
    push_exp(0, REQ_CPU, 1'b1, 32'hC0DE0006, c + 3);
    push_exp(0, REQ_DMA, 1'b1, 32'hC0DE0007, c + 7);
    push_exp(0, REQ_CPU, 1'b1, 32'hC0DE0006, c + 11);
    push_exp(0, REQ_DMA, 1'b1, 32'hC0DE0007, c + 15);
    drive(0, REQ_CPU, 1'b1, 1'b0, 32'h18, 32'd0);
    drive(0, REQ_DMA, 1'b1, 1'b0, 32'h1C, 32'd0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (seen_cpu[0]) n++;
      if (seen_dma[0]) n++;
      cpu_req[0] = !seen_cpu[0] && (n < 4);
      dma_req[0] = !seen_dma[0] && (n < 4);
    end
    cpu_req[0] = 1'b0;
    dma_req[0] = 1'b0;
    chk("rr_ready_count", 32'(n), 32'd4);
    tick();

    for (int i = 0; i < 10; i++) do_single(vecs[i]);

    // Address change and req drop after grant do not disturb the access.
    c = cyc;
    push_exp(0, REQ_CPU, 1'b1, 32'hDEADBEEF, c + 3);
    drive(0, REQ_CPU, 1'b1, 1'b0, 32'h10, 32'd0);
    tick();
    chk("hold_addr_busy1", mem_addr[0], 32'h10);
    cpu_addr[0] = 32'h20;
    cpu_req[0]  = 1'b0;
    tick();
    chk("hold_addr_busy2", mem_addr[0], 32'h10);
    chk("hold_mem_en", 32'(mem_en[0]), 32'd1);
    wait_ready(0, REQ_CPU, 10);
    tick();

    // Reset during the first BUSY cycle of a LAT=3 DMA write.
    drive(1, REQ_DMA, 1'b1, 1'b1, 32'h80, 32'hFEEDF00D);
    tick();
    chk("abort_busy", 32'(busy[1]), 32'd1);
    chk("abort_strobe_seen", 32'(mem_we[1]), 32'd1);
    rst[1] = 1'b1;
    tick();
    check_idle(1);
    rst[1] = 1'b0;
    drive(1, REQ_DMA, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (6) tick();
    chk("abort_no_write", mem[32], 32'hC0DE0020);

    // First tie after reset goes to the cpu.
    c = cyc;
    push_exp(1, REQ_CPU, 1'b1, 32'hC0DE0021, c + 4);
    drive(1, REQ_CPU, 1'b1, 1'b0, 32'h84, 32'd0);
    drive(1, REQ_DMA, 1'b1, 1'b0, 32'h88, 32'd0);
    tick();
    chk("tie_grant_cpu", 32'(grant[1]), 32'(REQ_CPU));
    drive(1, REQ_CPU, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, REQ_DMA, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ready(1, REQ_CPU, 10);
    repeat (3) tick();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single unified memory port of the multicycle MIPS system. It shares that port between the core (fetch, lw/sw/lb/lbu traffic issued by the main-decoder FSM) and a DMA/loader port. Arbitration is round-robin, and each access is sequenced through a fixed-latency memory with a wait-state counter. The block sits between the core's memory interface and the memory instance; the core stalls on `cpu_ready` low.

## Interface
Parameters:
- `AW`, default 32, address width
- `DW`, default 32, data width
- `LAT`, default 2, memory latency in cycles (legal range 1..15)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_req`, `dma_req`  in  1  level request
- `cpu_we`, `dma_we`  in  1  1 = write, 0 = read
- `cpu_addr`, `dma_addr`  in  AW  byte address
- `cpu_wdata`, `dma_wdata`  in  DW  write data
- `cpu_rdata`, `dma_rdata`  out  DW  read data, valid while the matching ready is high
- `cpu_ready`, `dma_ready`  out  1  one-cycle completion pulse
- `mem_en`  out  1  memory access active
- `mem_we`  out  1  memory write strobe
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data
- `grant`  out  1  owner of the current or last access: 0 = cpu, 1 = dma
- `busy`  out  1  state != IDLE

## Operation
- FSM states are IDLE, BUSY and DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester that did not win last (round-robin).
  - On grant: latch we/addr/wdata of the winner into internal registers, load the wait counter with LAT-1, set `grant`, and go to BUSY.
- **BUSY**
  - `mem_en` = 1. `mem_addr`/`mem_wdata` are driven from the latched registers.
  - `mem_we` = latched we, high in the first BUSY cycle only. Exactly one write strobe per write.
  - The counter decrements each cycle. When counter = 0: capture `mem_rdata` into the read register (reads only) and go to DONE.
- **DONE**
  - Pulse the winner's ready for one cycle. The read register drives the winner's rdata.
  - Update the last-winner register. Go to IDLE.
- Requester protocol:
  - Signals are sampled only at grant. Later changes, including dropping req, do not affect the access, and ready still pulses.
  - The requester must drop req on the edge where it samples ready high. Req still high in the following IDLE cycle is a new request.
- The non-winner's ready stays 0. Its rdata holds its previous value.
- A write leaves the read register unchanged.

## Timing
- Reset values:
  - State = IDLE, last-winner = dma (so cpu wins the first tie), `grant` = 0.
  - All ready, `mem_en`, `mem_we` = 0. `mem_addr`, `mem_wdata`, rdata registers = 0. `busy` = 0.
- Grant at edge t (IDLE sample). BUSY occupies cycles t+1..t+LAT. Ready is high in cycle t+LAT+1.
  - Latency is LAT+1 cycles from the request-sampling edge to ready.
  - Throughput is one access per LAT+2 cycles; IDLE costs one bubble between accesses.
- The memory returns read data LAT cycles after the first `mem_en` cycle. The arbiter samples it in the last BUSY cycle.
- Reset asserted in any state:
  - The next cycle is IDLE with all outputs at their reset values.
  - A write whose strobe has not yet occurred is never issued. The in-flight requester gets no ready.
- Req asserted in DONE is not seen until IDLE.
- LAT = 1 gives one BUSY cycle, so the strobe and the capture fall in the same cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - `arbstate_t` enum {IDLE, BUSY, DONE}, logic [1:0].
  - Requester ID constants `REQ_CPU` = 1'b0 and `REQ_DMA` = 1'b1.
- Sub-module `rr_arb2`:
  - Combinational 2-way round-robin pick with a registered last-winner.
  - Inputs: `clk`, `reset`, req[1:0], update.
  - Outputs: winner, valid.
- Top: FSM, wait counter (4 bits), latched request registers, read register, output muxing.

## Test plan
1. Reset, then only `cpu_req` read at addr 0x10 with LAT = 2, memory returning 0xDEADBEEF:
   - `mem_en` high for 2 cycles.
   - `cpu_ready` high exactly 3 cycles after the grant edge with `cpu_rdata` = 0xDEADBEEF.
   - `dma_ready` stays 0.
2. Both requesters held high continuously, acknowledging each ready:
   - Grant order cpu, dma, cpu, dma.
   - Ready pulses 4 cycles apart.
3. DMA write of 0x12345678 to 0x40:
   - `mem_we` high for exactly 1 cycle with `mem_addr` = 0x40.
   - `dma_ready` pulses once; `dma_rdata` is unchanged.
4. CPU changes `cpu_addr` from 0x10 to 0x20 and drops req one cycle after grant:
   - `mem_addr` stays 0x10 throughout BUSY.
   - `cpu_ready` still pulses.
5. Reset asserted in the first BUSY cycle of a DMA write, with LAT = 3:
   - The next cycle is IDLE with all outputs at reset values and `dma_ready` never pulses.
   - A subsequent tie is granted to cpu.
6. LAT = 1 read:
   - One BUSY cycle; ready 2 cycles after the grant edge with correct data.
